// File: rtl/rom_stream_loader.sv
// ---------------------------------------------------------------------------
// rom_stream_loader
//
// Loads a CHIP-8 program image, delivered as a valid/ready byte stream, into
// main memory starting at LOAD_BASE. It can optionally zero the program
// region [LOAD_BASE, MEM_DEPTH-1] first. It reports the number of bytes
// written and flags images larger than the program region. A new load can be
// requested from IDLE, DONE or ERR without a reset.
//
// Ports
//   clk_in     in   system clock, rising edge
//   rst_in     in   synchronous active-high reset
//   start_in   in   single-cycle load request (IDLE/DONE/ERR only)
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_last    in   final byte of the image, qualified by in_valid
//   in_ready   out  loader accepts a beat this cycle (LOAD state only)
//   mem_we     out  registered memory write enable
//   mem_addr   out  registered memory write address
//   mem_wdata  out  registered memory write data
//   rom_ready  out  image fully committed to memory
//   rom_error  out  image exceeded capacity, load aborted
//   rom_size   out  bytes written by the last load
//
// State table
//   state  | meaning
//   IDLE   | after reset, waiting for start_in
//   CLEAR  | zeroing LOAD_BASE..MEM_DEPTH-1, one word per cycle
//   LOAD   | accepting stream beats, each written the following cycle
//   COMMIT | final byte's write is on the memory port this cycle
//   DONE   | image loaded, rom_ready/rom_size held
//   ERR    | too many beats, load aborted, rest of stream left unconsumed
// ---------------------------------------------------------------------------
module rom_stream_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_DEPTH      = 4096,
    parameter int LOAD_BASE      = 'h200,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  rom_ready,
    output logic                  rom_error,
    output logic [ADDR_WIDTH:0]   rom_size
);

    // Capacity needs one extra bit: with LOAD_BASE=0 it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   CAP       = (ADDR_WIDTH+1)'(MEM_DEPTH - LOAD_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD   = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH:0]     count, count_d;
    logic [ADDR_WIDTH:0]     clear_left, clear_left_d;
    logic                    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_d;
    logic                    rom_ready_d;
    logic                    rom_error_d;
    logic [ADDR_WIDTH:0]     rom_size_d;

    // count never exceeds CAP-1 when a write is issued, so the sum stays
    // inside the memory and fits ADDR_WIDTH bits.
    logic [ADDR_WIDTH-1:0]   load_addr;
    assign load_addr = BASE_ADDR + count[ADDR_WIDTH-1:0];

    assign in_ready = (state == S_LOAD);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            count      <= '0;
            clear_left <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rom_ready  <= 1'b0;
            rom_error  <= 1'b0;
            rom_size   <= '0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            clear_left <= clear_left_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            rom_ready  <= rom_ready_d;
            rom_error  <= rom_error_d;
            rom_size   <= rom_size_d;
        end
    end

    always_comb begin
        state_d      = state;
        count_d      = count;
        clear_left_d = clear_left;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        rom_ready_d  = rom_ready;
        rom_error_d  = rom_error;
        rom_size_d   = rom_size;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_in) begin
                    rom_ready_d = 1'b0;
                    rom_error_d = 1'b0;
                    rom_size_d  = '0;
                    count_d     = '0;
                    if (CLEAR_ON_START) begin
                        // First clear write is issued on entry so that the
                        // CLEAR state lasts exactly CAP cycles.
                        state_d      = S_CLEAR;
                        clear_left_d = CAP - 1'b1;
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE_ADDR;
                        mem_wdata_d  = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_CLEAR: begin
                // clear_left counts the writes still to issue after the one
                // currently on the port; zero means this is MEM_DEPTH-1.
                if (clear_left == '0) begin
                    state_d = S_LOAD;
                end else begin
                    clear_left_d = clear_left - 1'b1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = mem_addr + 1'b1;
                    mem_wdata_d  = '0;
                end
            end

            S_LOAD: begin
                if (in_valid) begin
                    if (count == CAP) begin
                        // Beat beyond the last memory word: drop it and abort.
                        state_d     = S_ERR;
                        rom_error_d = 1'b1;
                        rom_ready_d = 1'b0;
                        rom_size_d  = CAP;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = load_addr;
                        mem_wdata_d = in_data;
                        count_d     = count + 1'b1;
                        if (in_last) begin
                            state_d    = S_COMMIT;
                            rom_size_d = count + 1'b1;
                        end
                    end
                end
            end

            S_COMMIT: begin
                state_d     = S_DONE;
                rom_ready_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_stream_loader.sv
module tb_rom_stream_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: no clear on start
    logic        rst0, start0, valid0, last0;
    logic [7:0]  data0;
    logic        ready0, we0, rdy0, err0;
    logic [11:0] addr0;
    logic [7:0]  wdata0;
    logic [12:0] size0;

    // dut1: clear on start
    logic        rst1, start1, valid1, last1;
    logic [7:0]  data1;
    logic        ready1, we1, rdy1, err1;
    logic [11:0] addr1;
    logic [7:0]  wdata1;
    logic [12:0] size1;

    int total = 0;
    int bad   = 0;

    rom_stream_loader #(.CLEAR_ON_START(1'b0)) dut0 (
        .clk_in(clk), .rst_in(rst0), .start_in(start0),
        .in_data(data0), .in_valid(valid0), .in_last(last0), .in_ready(ready0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .rom_ready(rdy0), .rom_error(err0), .rom_size(size0)
    );

    rom_stream_loader #(.CLEAR_ON_START(1'b1)) dut1 (
        .clk_in(clk), .rst_in(rst1), .start_in(start1),
        .in_data(data1), .in_valid(valid1), .in_last(last1), .in_ready(ready1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .rom_ready(rdy1), .rom_error(err1), .rom_size(size1)
    );

    // Memory model behind dut0 plus write bookkeeping.
    logic [7:0]  shadow [0:4095];
    int          we_cnt0  = 0;
    int          gap_we0  = 0;
    logic [11:0] last_addr0 = '0;
    logic        hs_prev0 = 1'b0;

    always @(posedge clk) begin
        if (we0) begin
            shadow[addr0] = wdata0;
            we_cnt0++;
            last_addr0 = addr0;
            if (!hs_prev0) gap_we0++;
        end
        hs_prev0 = valid0 && ready0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat0(input logic [7:0] d, input logic l);
        valid0 = 1'b1;
        data0  = d;
        last0  = l;
        tick();
        valid0 = 1'b0;
        last0  = 1'b0;
    endtask

    task automatic start_dut0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    function automatic logic [7:0] img(input int i);
        return 8'(i * 37 + 5);
    endfunction

    function automatic logic [7:0] img2(input int i);
        return 8'(i ^ (i >> 4));
    endfunction

    initial begin
        int   sent, cyc, k, cerr, mism, base, gbase;
        logic hs;

        rst0 = 1'b1; start0 = 1'b0; valid0 = 1'b0; last0 = 1'b0; data0 = '0;
        rst1 = 1'b1; start1 = 1'b0; valid1 = 1'b0; last1 = 1'b0; data1 = '0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready",  ready0, 0);
        chk("rst_mem_we",    we0,    0);
        chk("rst_mem_addr",  addr0,  0);
        chk("rst_mem_wdata", wdata0, 0);
        chk("rst_rom_ready", rdy0,   0);
        chk("rst_rom_error", err0,   0);
        chk("rst_rom_size",  size0,  0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();
        chk("idle_in_ready", ready0, 0);

        // 1: four-byte image, no gaps
        start_dut0();
        chk("t1_in_ready", ready0, 1);
        base = we_cnt0;
        for (int i = 0; i < 4; i++) begin
            beat0(8'hA0 + 8'(i), i == 3);
            chk($sformatf("t1_we_%0d", i),    we0,    1);
            chk($sformatf("t1_addr_%0d", i),  addr0,  32'h200 + i);
            chk($sformatf("t1_wdata_%0d", i), wdata0, 32'hA0 + i);
        end
        chk("t1_size_n1",  size0,  4);
        chk("t1_ready_n1", rdy0,   0);
        chk("t1_inrdy_n1", ready0, 0);
        tick();
        chk("t1_ready_n2", rdy0, 1);
        chk("t1_we_n2",    we0,  0);
        chk("t1_writes",   we_cnt0 - base, 4);

        // 6b: start in DONE begins a new load
        start_dut0();
        chk("t6_ready_drop", rdy0,   0);
        chk("t6_size_clr",   size0,  0);
        chk("t6_in_ready",   ready0, 1);

        // 6a: start during LOAD is ignored
        beat0(8'h11, 1'b0);
        chk("t6_addr0", addr0, 12'h200);
        start_dut0();
        chk("t6_load_ready", ready0, 1);
        chk("t6_load_we",    we0,    0);
        beat0(8'h22, 1'b1);
        chk("t6_addr1",  addr0,  12'h201);
        chk("t6_wdata1", wdata0, 8'h22);
        chk("t6_size",   size0,  2);
        tick();
        chk("t6_done", rdy0, 1);

        // 3: 256-byte image with random in_valid gaps
        start_dut0();
        base  = we_cnt0;
        gbase = gap_we0;
        sent  = 0;
        cyc   = 0;
        while (sent < 256 && cyc < 2000) begin
            valid0 = ($urandom_range(0, 2) != 0);
            data0  = img(sent);
            last0  = (sent == 255);
            hs     = valid0 && ready0;
            tick();
            if (hs) sent++;
            cyc++;
        end
        valid0 = 1'b0;
        last0  = 1'b0;
        chk("t3_sent", sent, 256);
        tick();
        chk("t3_ready",  rdy0,  1);
        chk("t3_size",   size0, 256);
        chk("t3_writes", we_cnt0 - base, 256);
        chk("t3_gap_writes", gap_we0 - gbase, 0);
        mism = 0;
        for (int i = 0; i < 256; i++)
            if (shadow[12'h200 + 12'(i)] !== img(i)) mism++;
        chk("t3_mem_mismatches", mism, 0);

        // 4a: image exactly filling capacity
        start_dut0();
        base = we_cnt0;
        for (int i = 0; i < 3584; i++)
            beat0(img2(i), i == 3583);
        tick();
        chk("t4_ready",     rdy0,  1);
        chk("t4_error",     err0,  0);
        chk("t4_size",      size0, 3584);
        chk("t4_last_addr", last_addr0, 12'hFFF);
        chk("t4_writes",    we_cnt0 - base, 3584);
        mism = 0;
        for (int i = 0; i < 3584; i++)
            if (shadow[12'h200 + 12'(i)] !== img2(i)) mism++;
        chk("t4_mem_mismatches", mism, 0);

        // 4b: one beat too many
        start_dut0();
        base = we_cnt0;
        for (int i = 0; i < 3585; i++)
            beat0(8'(i), 1'b0);
        chk("t4_err_flag",   err0,   1);
        chk("t4_err_ready",  rdy0,   0);
        chk("t4_err_size",   size0,  3584);
        chk("t4_err_inrdy",  ready0, 0);
        chk("t4_err_we",     we0,    0);
        valid0 = 1'b1;
        tick();
        tick();
        valid0 = 1'b0;
        chk("t4_err_writes", we_cnt0 - base, 3584);
        chk("t4_err_hold",   err0,   1);
        chk("t4_err_final",  shadow[12'hFFF], 8'hFF);

        // 5: reset mid-LOAD, then a fresh image
        start_dut0();
        for (int i = 0; i < 10; i++)
            beat0(8'h40 + 8'(i), 1'b0);
        rst0 = 1'b1;
        tick();
        chk("t5_in_ready", ready0, 0);
        chk("t5_we",       we0,    0);
        chk("t5_addr",     addr0,  0);
        chk("t5_wdata",    wdata0, 0);
        chk("t5_ready",    rdy0,   0);
        chk("t5_error",    err0,   0);
        chk("t5_size",     size0,  0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        rst0   = 1'b0;
        tick();
        chk("t5_rst_wins", ready0, 0);
        start_dut0();
        beat0(8'hE1, 1'b0);
        chk("t5_first_addr",  addr0,  12'h200);
        chk("t5_first_wdata", wdata0, 8'hE1);
        beat0(8'hE2, 1'b0);
        beat0(8'hE3, 1'b1);
        chk("t5_last_addr", addr0, 12'h202);
        chk("t5_size3",     size0, 3);
        tick();
        chk("t5_done", rdy0, 1);

        // 2: clear on start, then a one-byte image
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k    = 0;
        cerr = 0;
        while (!ready1 && k < 4000) begin
            if (!(we1 === 1'b1 && addr1 === 12'(32'h200 + k) && wdata1 === 8'h00)) cerr++;
            k++;
            tick();
        end
        chk("t2_clear_cycles", k,      3584);
        chk("t2_clear_errors", cerr,   0);
        chk("t2_in_ready",     ready1, 1);
        chk("t2_load_we",      we1,    0);
        valid1 = 1'b1;
        data1  = 8'hC3;
        last1  = 1'b1;
        tick();
        valid1 = 1'b0;
        last1  = 1'b0;
        chk("t2_we",    we1,    1);
        chk("t2_addr",  addr1,  12'h200);
        chk("t2_wdata", wdata1, 8'hC3);
        chk("t2_size",  size1,  1);
        tick();
        chk("t2_ready", rdy1, 1);
        chk("t2_error", err1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
